beta_sequencer: RTL and testbench
=================================

# beta_sequencer

Sequencer for the backward (beta) recursion of the max-product turbo decoder. On a start request it reads a stored block of branch-metric vectors from the branch-metric memory in reverse symbol order. It drives the valid/block-start controls of the streaming beta unit in step with the returning read data. It also generates the matching write strobe and address for the beta-metric memory, with start/busy/done/abort handshakes toward the decoder top-level controller.

## Interface
Parameters:
- SYMBOLS, 10, maximum symbols per block.
- RD_LATENCY, 1, branch-metric memory read latency in cycles (1..4).
- ADDR_W, $clog2(SYMBOLS) (minimum 1), symbol address width.

Ports:
- clk, input, 1, single clock, all logic rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, block start request; sampled only in IDLE.
- abort, input, 1, cancel current block; highest priority.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse after the last beta write.
- aborted, output, 1, one-cycle pulse acknowledging an abort.
- bm_rd_en, output, 1, branch-metric memory read enable.
- bm_rd_addr, output, ADDR_W, read address.
- beta_in_valid, output, 1, to streaming beta unit in_valid.
- beta_block_start, output, 1, to streaming beta unit block_start; marks the first (last-in-time) symbol.
- beta_wr_en, output, 1, beta-metric memory write enable; equals beta_in_valid.
- beta_wr_addr, output, ADDR_W, symbol index of the beta currently presented.

## Operation
- Block length N = SYMBOLS, or the runtime length when the variable-length feature is configured (see Configuration).
- States and transitions:
  - IDLE: start → ISSUE (N≥1), or → DONE (N=0).
  - ISSUE: issue one read per cycle at addresses N-1 down to 0. After issuing address 0 → DRAIN.
  - DRAIN: wait until the read-valid pipeline is empty → DONE.
  - DONE: pulse done → IDLE.
- Read tracking:
  - RD_LATENCY-deep shift register carries (valid, addr, first) for each issued read.
  - Its output drives beta_in_valid, beta_wr_addr and beta_block_start.
  - beta_block_start is high only with the data for address N-1.
- Abort:
  - abort in any non-IDLE state → IDLE next cycle.
  - The read pipeline is cleared and aborted pulses for one cycle. No done is issued.
  - abort in IDLE is ignored. abort has priority over start in the same cycle.
- start is ignored while busy, including in DONE. A start in IDLE the cycle after DONE is accepted.
- The address counter is a down-counter and never wraps: issue stops at 0.

## Timing
- Reset: state IDLE, pipeline cleared. Every output is 0: busy, done, aborted, bm_rd_en, bm_rd_addr, beta_in_valid, beta_block_start, beta_wr_en, beta_wr_addr.
- With start sampled at edge 0:
  - bm_rd_en is high for cycles 1..N, with bm_rd_addr = N-1-(k-1) in cycle k.
  - beta_in_valid is high for cycles 1+RD_LATENCY .. N+RD_LATENCY, continuous with no gaps.
  - beta_block_start is high in cycle 1+RD_LATENCY.
  - done is high in cycle N+RD_LATENCY+1.
  - busy is high for cycles 1..N+RD_LATENCY+1.
- All outputs are registered. The streaming beta unit consumes beta_in_valid combinationally, so the beta write aligns with the same cycle.
- Minimum start-to-start interval: N+RD_LATENCY+2 cycles.

## Configuration
- BETA_SEQ_VARLEN_EN defined:
  - Adds port blk_len, input, ADDR_W+1 bits, sampled together with start in IDLE.
  - N = min(blk_len, SYMBOLS).
  - blk_len = 0 produces done in cycle 1 with no reads or beta writes.
- Not defined: no blk_len port, and N = SYMBOLS always.

## Test plan
- Default parameters (SYMBOLS=10, RD_LATENCY=1), single start → reads at addresses 9..0 in cycles 1..10. beta_in_valid in cycles 2..11, block_start only in cycle 2 with wr_addr=9, done in cycle 12.
- RD_LATENCY=3, back-to-back starts (second start issued in the first cycle IDLE is reached) → both blocks complete. Second block's read at address 9 comes 15 cycles after the first block's. No start is accepted while busy.
- abort asserted in cycle 5 of a block → IDLE at cycle 6, aborted pulse, no done. Pipeline valids cleared with no further beta_wr_en. A new start afterwards gives a normal block.
- rst_n asserted mid-DRAIN → all outputs 0 immediately (asynchronous). After release, start produces a clean full block.
- abort and start in the same IDLE cycle → start ignored, no aborted pulse, busy stays 0.
- With BETA_SEQ_VARLEN_EN: blk_len=4 → reads at addresses 3..0 and done in cycle 6. blk_len=15 → clamped to 10. blk_len=0 → done in cycle 1 with no reads.

Source files
------------

// File: rtl/beta_sequencer.sv
// Backward-recursion sequencer: reads a branch-metric block last-to-first and streams beta strobes.
// Latency: first read 1 cycle after start, first beta strobe RD_LATENCY later, done N+RD_LATENCY+1 after start.
// No backpressure: the beta unit is always ready; start is ignored while busy; optional BETA_SEQ_VARLEN_EN adds blk_len.
module beta_sequencer #(
    parameter int SYMBOLS    = 10,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
`ifdef BETA_SEQ_VARLEN_EN
    input  logic [ADDR_W:0]   blk_len,
`endif
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              bm_rd_en,
    output logic [ADDR_W-1:0] bm_rd_addr,
    output logic              beta_in_valid,
    output logic              beta_block_start,
    output logic              beta_wr_en,
    output logic [ADDR_W-1:0] beta_wr_addr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_aborted;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_first;

    // Read-return tracking: stage RD_LATENCY-1 lines up with the returning memory data.
    logic [RD_LATENCY-1:0] r_pv;
    logic [RD_LATENCY-1:0] r_pf;
    logic [ADDR_W-1:0]     r_pa [RD_LATENCY];

    logic                w_len_zero;
    logic [ADDR_W-1:0]   w_first_addr;
    logic                w_pipe_fill;
    logic                w_abort_hit;

`ifdef BETA_SEQ_VARLEN_EN
    logic [ADDR_W:0]     w_len;

    always_comb begin
        w_len        = (blk_len > (ADDR_W+1)'(SYMBOLS)) ? (ADDR_W+1)'(SYMBOLS) : blk_len;
        w_len_zero   = (w_len == '0);
        w_first_addr = ADDR_W'(w_len - (ADDR_W+1)'(1));
    end
`else
    always_comb begin
        w_len_zero   = 1'b0;
        w_first_addr = ADDR_W'(SYMBOLS - 1);
    end
`endif

    // Stages feeding the output stage; once empty, the last strobe is on its way out.
    always_comb begin
        w_pipe_fill = 1'b0;
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            w_pipe_fill = w_pipe_fill | r_pv[i];
        end
    end

    assign w_abort_hit = abort && (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_first <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (w_abort_hit) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_aborted  <= 1'b1;
                r_rd_en    <= 1'b0;
                r_rd_addr  <= '0;
                r_rd_first <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_busy <= 1'b1;
                            if (w_len_zero) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= ST_ISSUE;
                                r_rd_en    <= 1'b1;
                                r_rd_addr  <= w_first_addr;
                                r_rd_first <= 1'b1;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        r_rd_first <= 1'b0;
                        if (r_rd_addr == '0) begin
                            r_rd_en <= 1'b0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_rd_addr <= r_rd_addr - ADDR_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (!w_pipe_fill) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_pf <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pa[i] <= '0;
            end
        end else if (w_abort_hit) begin
            r_pv <= '0;
            r_pf <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pa[i] <= '0;
            end
        end else begin
            r_pv[0] <= r_rd_en;
            r_pf[0] <= r_rd_first;
            r_pa[0] <= r_rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pf[i] <= r_pf[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign aborted          = r_aborted;
    assign bm_rd_en         = r_rd_en;
    assign bm_rd_addr       = r_rd_addr;
    assign beta_in_valid    = r_pv[RD_LATENCY-1];
    assign beta_wr_en       = r_pv[RD_LATENCY-1];
    assign beta_block_start = r_pf[RD_LATENCY-1];
    assign beta_wr_addr     = r_pa[RD_LATENCY-1];

endmodule

// File: tb/tb_beta_sequencer.sv
// Bench for beta_sequencer: two instances (read latency 1 and 3) against a cycle-schedule reference model.
module tb_beta_sequencer;

    localparam int AW    = 4;
    localparam int NSYM  = 10;
    localparam int DEPTH = 4096;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          abrt;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic          iv;
        logic          bs;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, abort_a, start_b, abort_b;
`ifdef BETA_SEQ_VARLEN_EN
    logic [AW:0] blk_a, blk_b;
`endif

    logic          a_busy, a_done, a_abrt, a_rd_en, a_iv, a_bs, a_wr_en;
    logic [AW-1:0] a_rd_addr, a_wr_addr;
    logic          b_busy, b_done, b_abrt, b_rd_en, b_iv, b_bs, b_wr_en;
    logic [AW-1:0] b_rd_addr, b_wr_addr;

    beta_sequencer #(.SYMBOLS(NSYM), .RD_LATENCY(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
`ifdef BETA_SEQ_VARLEN_EN
        .blk_len(blk_a),
`endif
        .busy(a_busy), .done(a_done), .aborted(a_abrt),
        .bm_rd_en(a_rd_en), .bm_rd_addr(a_rd_addr),
        .beta_in_valid(a_iv), .beta_block_start(a_bs),
        .beta_wr_en(a_wr_en), .beta_wr_addr(a_wr_addr)
    );

    beta_sequencer #(.SYMBOLS(NSYM), .RD_LATENCY(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
`ifdef BETA_SEQ_VARLEN_EN
        .blk_len(blk_b),
`endif
        .busy(b_busy), .done(b_done), .aborted(b_abrt),
        .bm_rd_en(b_rd_en), .bm_rd_addr(b_rd_addr),
        .beta_in_valid(b_iv), .beta_block_start(b_bs),
        .beta_wr_en(b_wr_en), .beta_wr_addr(b_wr_addr)
    );

    exp_t obs [2];
    always_comb begin
        obs[0] = {a_busy, a_done, a_abrt, a_rd_en, a_rd_addr, a_iv, a_bs, a_wr_en, a_wr_addr};
        obs[1] = {b_busy, b_done, b_abrt, b_rd_en, b_rd_addr, b_iv, b_bs, b_wr_en, b_wr_addr};
    end

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q [2][DEPTH];
    int   busy_last [2];
    int   lat [2];
    int   total = 0;
    int   bad   = 0;

    // Expected outputs per cycle; a start/abort seen in cycle c rewrites the schedule from c+1.
    task automatic model_step(input int i, input logic s, input logic a, input int len);
        int c;
        int n;
        int l;
        c = cyc;
        l = lat[i];
        n = (len > NSYM) ? NSYM : len;
        if (exp_q[i][c].busy) begin
            if (a) begin
                for (int t = c + 1; t <= busy_last[i]; t++) exp_q[i][t] = '0;
                exp_q[i][c+1].abrt = 1'b1;
                busy_last[i] = c;
            end
        end else if (s && !a) begin
            if (n == 0) begin
                exp_q[i][c+1].busy = 1'b1;
                exp_q[i][c+1].done = 1'b1;
                busy_last[i] = c + 1;
            end else begin
                for (int k = 1; k <= n + l + 1; k++) exp_q[i][c+k].busy = 1'b1;
                for (int k = 1; k <= n; k++) begin
                    exp_q[i][c+k].rd_en   = 1'b1;
                    exp_q[i][c+k].rd_addr = AW'(n - k);
                end
                for (int j = 0; j < n; j++) begin
                    exp_q[i][c+1+l+j].iv      = 1'b1;
                    exp_q[i][c+1+l+j].wr_en   = 1'b1;
                    exp_q[i][c+1+l+j].wr_addr = AW'(n - 1 - j);
                    exp_q[i][c+1+l+j].bs      = (j == 0);
                end
                exp_q[i][c+n+l+1].done = 1'b1;
                busy_last[i] = c + n + l + 1;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int t = cyc; t < cyc + 64; t++) exp_q[i][t] = '0;
            busy_last[i] = cyc - 1;
        end
    endtask

    task automatic drive(input logic sa, input logic aa, input logic sb, input logic ab,
                         input int la, input int lb);
        start_a = sa; abort_a = aa; start_b = sb; abort_b = ab;
`ifdef BETA_SEQ_VARLEN_EN
        blk_a = (AW+1)'(la);
        blk_b = (AW+1)'(lb);
`endif
        model_step(0, sa, aa, la);
        model_step(1, sb, ab, lb);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) rst_n = 1'b1;
            drive(1'b0, 1'b0, 1'b0, 1'b0, NSYM, NSYM);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_q[i][cyc]) begin
                    bad++;
                    $display("FAIL reset lat=%0d cyc=%0d got=%h want=%h", lat[i], cyc, obs[i], exp_q[i][cyc]);
                end
            end
        end
    endtask

    task automatic test_single();
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            drive(k == 0, 1'b0, k == 0, 1'b0, NSYM, NSYM);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_q[i][cyc]) begin
                    bad++;
                    $display("FAIL single lat=%0d cyc=%0d got=%h want=%h", lat[i], cyc, obs[i], exp_q[i][cyc]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 56; k++) begin
            @(posedge clk); #1;
            drive(k < 40, 1'b0, k < 40, 1'b0, NSYM, NSYM);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_q[i][cyc]) begin
                    bad++;
                    $display("FAIL back_to_back lat=%0d cyc=%0d got=%h want=%h", lat[i], cyc, obs[i], exp_q[i][cyc]);
                end
            end
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            drive(k == 0 || k == 8, k == 5, k == 0 || k == 8, k == 5, NSYM, NSYM);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_q[i][cyc]) begin
                    bad++;
                    $display("FAIL abort lat=%0d cyc=%0d got=%h want=%h", lat[i], cyc, obs[i], exp_q[i][cyc]);
                end
            end
        end
    endtask

    task automatic test_abort_start_idle();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            drive(k < 3, k < 3, k < 3, k < 3, NSYM, NSYM);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_q[i][cyc]) begin
                    bad++;
                    $display("FAIL abort_start_idle lat=%0d cyc=%0d got=%h want=%h", lat[i], cyc, obs[i], exp_q[i][cyc]);
                end
            end
        end
    endtask

    task automatic test_reset_drain();
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            drive(k == 0, 1'b0, k == 0, 1'b0, NSYM, NSYM);
            @(negedge clk);
        end
        // lat=3 instance is now in DRAIN; reset lands mid-cycle, before any edge
        @(posedge clk); #2;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_q[i][cyc]) begin
                bad++;
                $display("FAIL reset_drain_async lat=%0d cyc=%0d got=%h want=%h", lat[i], cyc, obs[i], exp_q[i][cyc]);
            end
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                model_reset();
                rst_n = 1'b1;
            end
            drive(k == 1, 1'b0, k == 1, 1'b0, NSYM, NSYM);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_q[i][cyc]) begin
                    bad++;
                    $display("FAIL reset_drain lat=%0d cyc=%0d got=%h want=%h", lat[i], cyc, obs[i], exp_q[i][cyc]);
                end
            end
        end
    endtask

`ifdef BETA_SEQ_VARLEN_EN
    task automatic test_varlen();
        int lens [3];
        lens[0] = 4; lens[1] = 15; lens[2] = 0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 17; k++) begin
                @(posedge clk); #1;
                drive(k == 0, 1'b0, k == 0, 1'b0, lens[b], lens[b]);
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    total++;
                    if (obs[i] !== exp_q[i][cyc]) begin
                        bad++;
                        $display("FAIL varlen len=%0d lat=%0d cyc=%0d got=%h want=%h", lens[b], lat[i], cyc, obs[i], exp_q[i][cyc]);
                    end
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        logic sa, aa, sb, ab;
        int   la, lb;
        for (int k = 0; k < 420; k++) begin
            @(posedge clk); #1;
            sa = (k < 400) && ($urandom_range(0, 2) == 0);
            sb = (k < 400) && ($urandom_range(0, 2) == 0);
            aa = (k < 400) && ($urandom_range(0, 19) == 0);
            ab = (k < 400) && ($urandom_range(0, 19) == 0);
`ifdef BETA_SEQ_VARLEN_EN
            la = int'($urandom_range(0, 15));
            lb = int'($urandom_range(0, 15));
`else
            la = NSYM;
            lb = NSYM;
`endif
            drive(sa, aa, sb, ab, la, lb);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_q[i][cyc]) begin
                    bad++;
                    $display("FAIL random lat=%0d cyc=%0d got=%h want=%h", lat[i], cyc, obs[i], exp_q[i][cyc]);
                end
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
`ifdef BETA_SEQ_VARLEN_EN
        blk_a = '0; blk_b = '0;
`endif
        lat[0] = 1; lat[1] = 3;
        busy_last[0] = -1; busy_last[1] = -1;
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < DEPTH; t++) exp_q[i][t] = '0;
        end

        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_abort_start_idle();
        test_reset_drain();
`ifdef BETA_SEQ_VARLEN_EN
        test_varlen();
`endif
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
